ripl_h_decimate: RTL and testbench

Parametrised horizontal stage for the saliency pyramid. It consumes a raster pixel stream on the In1 actor port and emits one output pixel per FACTOR input pixels along each row. The output is either the first pixel of each group (pick) or the truncated group mean (average). With FACTOR=1 it degenerates to a one-token pass-through level stage. A small output FIFO decouples the stage from downstream back-pressure.

---
 rtl/ripl_h_decimate_if.sv | 25 ++
 rtl/ripl_h_decimate.sv | 115 +++++++++++
 tb/tb_ripl_h_decimate.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ripl_h_decimate_if.sv
// Token-port bundle for the horizontal decimation stage.
// The In1 side carries the raster input and the Out1 side carries the decimated output.
interface ripl_h_decimate_if #(
    parameter int DATA_W = 16
) ();
    logic [DATA_W-1:0] In1_DATA;
    logic              In1_SEND;
    logic [15:0]       In1_COUNT;
    logic              In1_ACK;
    logic [DATA_W-1:0] Out1_DATA;
    logic              Out1_SEND;
    logic              Out1_RDY;
    logic              Out1_ACK;
    logic [15:0]       Out1_COUNT;

    modport slave (
        input  In1_DATA, In1_SEND, In1_COUNT, Out1_RDY, Out1_ACK,
        output In1_ACK, Out1_DATA, Out1_SEND, Out1_COUNT
    );

    modport master (
        output In1_DATA, In1_SEND, In1_COUNT, Out1_RDY, Out1_ACK,
        input  In1_ACK, Out1_DATA, Out1_SEND, Out1_COUNT
    );
endinterface

// File: rtl/ripl_h_decimate.sv
// Horizontal decimation stage of the saliency pyramid.
// For every FACTOR pixels it emits either the first pixel of the group or the truncated mean, buffered through a small output FIFO.
module ripl_h_decimate #(
    parameter int DATA_W     = 16,
    parameter int IMG_W      = 512,
    parameter int FACTOR     = 2,
    parameter int MODE       = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    ripl_h_decimate_if.slave     bus
);
    localparam int LOG2F = $clog2(FACTOR);
    localparam int ACC_W = DATA_W + LOG2F;
    localparam int PH_W  = (LOG2F > 0) ? LOG2F : 1;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);

    if (IMG_W % FACTOR != 0) begin : g_badImgW
        $error("ripl_h_decimate: IMG_W must be a multiple of FACTOR");
    end
    if (FACTOR < 1 || FACTOR > 16 || (FACTOR & (FACTOR - 1)) != 0) begin : g_badFactor
        $error("ripl_h_decimate: FACTOR must be a power of two in 1..16");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_badDepth
        $error("ripl_h_decimate: FIFO_DEPTH must be a power of two, at least 2");
    end
    if (MODE != 0 && MODE != 1) begin : g_badMode
        $error("ripl_h_decimate: MODE must be 0 (pick) or 1 (average)");
    end

    logic [PH_W-1:0]   r_phase;
    logic [COL_W-1:0]  r_col;
    logic [ACC_W-1:0]  r_acc;
    logic [DATA_W-1:0] r_pick;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wrPtr;
    logic [AW-1:0]     r_rdPtr;
    logic [AW:0]       r_count;

    logic              w_completing;
    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [ACC_W-1:0]  w_sum;
    logic [DATA_W-1:0] w_avg;
    logic [DATA_W-1:0] w_pushData;
    logic              w_unused;

    assign w_completing = (r_phase == PH_W'(FACTOR - 1));
    assign w_full       = (r_count == (AW + 1)'(FIFO_DEPTH));
    assign w_empty      = (r_count == '0);

    // Only the completing pixel needs FIFO space, so full never depends on Out1_RDY in the same cycle.
    assign w_accept = bus.In1_SEND & ~RESET & (~w_completing | ~w_full);
    assign w_push   = w_accept & w_completing;
    assign w_pop    = ~w_empty & bus.Out1_RDY;

    assign w_sum      = ((r_phase == '0) ? '0 : r_acc) + ACC_W'(bus.In1_DATA);
    assign w_avg      = DATA_W'(w_sum >> LOG2F);
    assign w_pushData = (MODE == 1) ? w_avg : ((FACTOR == 1) ? bus.In1_DATA : r_pick);

    assign bus.In1_ACK    = w_accept;
    assign bus.Out1_SEND  = w_pop;
    assign bus.Out1_DATA  = w_empty ? '0 : r_mem[r_rdPtr];
    assign bus.Out1_COUNT = 16'h1;

    assign w_unused = ^{bus.In1_COUNT, bus.Out1_ACK};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_phase <= '0;
            r_col   <= '0;
            r_acc   <= '0;
            r_pick  <= '0;
        end else if (w_accept) begin
            r_phase <= w_completing ? '0 : r_phase + PH_W'(1);
            r_col   <= (r_col == COL_W'(IMG_W - 1)) ? '0 : r_col + COL_W'(1);
            r_acc   <= w_sum;
            if (r_phase == '0) begin
                r_pick <= bus.In1_DATA;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the read side is gated by the occupancy count.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= w_pushData;
        end
    end
endmodule

// File: tb/tb_ripl_h_decimate.sv
// Directed bench for ripl_h_decimate: three instances cover pass-through, pick with FIFO depth 2, and average mode.
// Expected outputs are hand-computed constants in the vector table and the corner-case sequences.
module tb_ripl_h_decimate;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] inData [3];
    logic        inSend [3];
    logic        outRdy [3];
    logic        ack    [3];
    logic [15:0] oData  [3];
    logic        oSend  [3];
    logic [15:0] oCount [3];

    int nTests = 0;
    int nFail  = 0;
    int cyc    = 0;

    ripl_h_decimate_if #(.DATA_W(16)) ifA ();
    ripl_h_decimate_if #(.DATA_W(16)) ifB ();
    ripl_h_decimate_if #(.DATA_W(16)) ifC ();

    assign ifA.In1_DATA = inData[0];
    assign ifA.In1_SEND = inSend[0];
    assign ifA.In1_COUNT = 16'h0;
    assign ifA.Out1_RDY = outRdy[0];
    assign ifA.Out1_ACK = 1'b0;
    assign ack[0] = ifA.In1_ACK;
    assign oData[0] = ifA.Out1_DATA;
    assign oSend[0] = ifA.Out1_SEND;
    assign oCount[0] = ifA.Out1_COUNT;

    assign ifB.In1_DATA = inData[1];
    assign ifB.In1_SEND = inSend[1];
    assign ifB.In1_COUNT = 16'h0;
    assign ifB.Out1_RDY = outRdy[1];
    assign ifB.Out1_ACK = 1'b0;
    assign ack[1] = ifB.In1_ACK;
    assign oData[1] = ifB.Out1_DATA;
    assign oSend[1] = ifB.Out1_SEND;
    assign oCount[1] = ifB.Out1_COUNT;

    assign ifC.In1_DATA = inData[2];
    assign ifC.In1_SEND = inSend[2];
    assign ifC.In1_COUNT = 16'h0;
    assign ifC.Out1_RDY = outRdy[2];
    assign ifC.Out1_ACK = 1'b0;
    assign ack[2] = ifC.In1_ACK;
    assign oData[2] = ifC.Out1_DATA;
    assign oSend[2] = ifC.Out1_SEND;
    assign oCount[2] = ifC.Out1_COUNT;

    ripl_h_decimate #(.DATA_W(16), .IMG_W(4), .FACTOR(1), .MODE(0), .FIFO_DEPTH(4)) uPass (
        .CLK(clk), .RESET(rst), .bus(ifA.slave));
    ripl_h_decimate #(.DATA_W(16), .IMG_W(4), .FACTOR(2), .MODE(0), .FIFO_DEPTH(2)) uPick (
        .CLK(clk), .RESET(rst), .bus(ifB.slave));
    ripl_h_decimate #(.DATA_W(16), .IMG_W(8), .FACTOR(4), .MODE(1), .FIFO_DEPTH(4)) uAvg (
        .CLK(clk), .RESET(rst), .bus(ifC.slave));

    typedef struct {
        int          dut;
        logic [15:0] pix [8];
        int          nPix;
        logic [15:0] exp [4];
        int          nExp;
        bit          checkLat;
        string       name;
    } vec_t;

    typedef struct {
        int          dut;
        logic [15:0] data;
        int          cyc;
        bit          isOut;
    } ev_t;

    vec_t vecs [5];
    ev_t  evQ [$];

    always @(posedge clk) cyc++;

    // Outputs and acks are sampled mid-cycle; each event stands for the transfer at the next rising edge.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (oSend[d] === 1'b1) evQ.push_back('{d, oData[d], cyc, 1'b1});
            if (ack[d] === 1'b1) evQ.push_back('{d, 16'h0, cyc, 1'b0});
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int d, input logic [15:0] v, input int gap);
        bit ok;
        ok = 1'b0;
        inData[d] = v;
        inSend[d] = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ack[d] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput($sformatf("ackTimeout_d%0d_v%0d", d, v), 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        inSend[d] = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int d = 0; d < 3; d++) outRdy[d] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic compareOuts(input int d, input logic [15:0] exp [4], input int nExp, input string name);
        logic [15:0] got [$];
        foreach (evQ[i]) if (evQ[i].dut == d && evQ[i].isOut) got.push_back(evQ[i].data);
        checkOutput({name, "_count"}, 32'(got.size()), 32'(nExp));
        for (int j = 0; j < nExp; j++)
            checkOutput($sformatf("%s_out%0d", name, j),
                        (j < got.size()) ? 32'(got[j]) : 32'hDEADBEEF, 32'(exp[j]));
    endtask

    task automatic runVec(input vec_t v, input int gap, input string tag);
        int accC [$];
        int outC [$];
        evQ.delete();
        for (int p = 0; p < v.nPix; p++) applyStimulus(v.dut, v.pix[p], gap);
        drain();
        compareOuts(v.dut, v.exp, v.nExp, {v.name, tag});
        if (v.checkLat) begin
            foreach (evQ[i]) begin
                if (evQ[i].dut == v.dut && evQ[i].isOut) outC.push_back(evQ[i].cyc);
                if (evQ[i].dut == v.dut && !evQ[i].isOut) accC.push_back(evQ[i].cyc);
            end
            for (int j = 0; j < v.nExp; j++) begin
                if (j < outC.size() && j < accC.size()) begin
                    checkOutput($sformatf("%s_latency%0d", v.name, j), 32'(outC[j] - accC[j]), 32'd1);
                    checkOutput($sformatf("%s_ackRun%0d", v.name, j), 32'(accC[j] - accC[0]), 32'(j));
                end else begin
                    checkOutput($sformatf("%s_stamps%0d", v.name, j), 32'(outC.size()), 32'(v.nExp));
                end
            end
        end
    endtask

    initial begin
        logic [15:0] e [4];

        vecs[0].dut = 0; vecs[0].nPix = 4; vecs[0].nExp = 4; vecs[0].checkLat = 1'b1; vecs[0].name = "pass";
        vecs[0].pix = '{10, 20, 30, 40, 0, 0, 0, 0};
        vecs[0].exp = '{10, 20, 30, 40};
        vecs[1].dut = 1; vecs[1].nPix = 8; vecs[1].nExp = 4; vecs[1].checkLat = 1'b0; vecs[1].name = "pickWrap";
        vecs[1].pix = '{1, 2, 3, 4, 5, 6, 7, 8};
        vecs[1].exp = '{1, 3, 5, 7};
        vecs[2].dut = 2; vecs[2].nPix = 8; vecs[2].nExp = 2; vecs[2].checkLat = 1'b0; vecs[2].name = "avgTrunc";
        vecs[2].pix = '{1, 2, 3, 4, 65535, 65535, 65535, 65534};
        vecs[2].exp = '{2, 65534, 0, 0};
        vecs[3].dut = 2; vecs[3].nPix = 8; vecs[3].nExp = 2; vecs[3].checkLat = 1'b0; vecs[3].name = "avgSmall";
        vecs[3].pix = '{5, 6, 7, 9, 0, 0, 0, 3};
        vecs[3].exp = '{6, 0, 0, 0};
        vecs[4].dut = 1; vecs[4].nPix = 4; vecs[4].nExp = 2; vecs[4].checkLat = 1'b0; vecs[4].name = "pickExtremes";
        vecs[4].pix = '{9, 100, 65535, 0, 0, 0, 0, 0};
        vecs[4].exp = '{9, 65535, 0, 0};

        for (int d = 0; d < 3; d++) begin
            inData[d] = 16'd5;
            inSend[d] = 1'b1;
            outRdy[d] = 1'b1;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("rstAck_d%0d", d), 32'(ack[d]), 32'd0);
            checkOutput($sformatf("rstSend_d%0d", d), 32'(oSend[d]), 32'd0);
            checkOutput($sformatf("rstData_d%0d", d), 32'(oData[d]), 32'd0);
            checkOutput($sformatf("rstCount_d%0d", d), 32'(oCount[d]), 32'd1);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) inSend[d] = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) runVec(vecs[i], 0, "");

        // Same average vectors with a one-cycle hole after every pixel.
        runVec(vecs[2], 1, "_gaps");
        runVec(vecs[3], 1, "_gaps");

        // Back-pressure on the depth-2 pick instance.
        evQ.delete();
        outRdy[1] = 1'b0;
        for (int v = 0; v < 5; v++) applyStimulus(1, 16'(v), 0);
        inData[1] = 16'd5;
        inSend[1] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("bpStallAck", 32'(ack[1]), 32'd0);
            checkOutput("bpNoSend", 32'(oSend[1]), 32'd0);
        end
        @(posedge clk);
        #1;
        outRdy[1] = 1'b1;
        @(negedge clk);
        checkOutput("bpPopSend", 32'(oSend[1]), 32'd1);
        checkOutput("bpHeadData", 32'(oData[1]), 32'd0);
        checkOutput("bpStallDuringPop", 32'(ack[1]), 32'd0);
        @(negedge clk);
        checkOutput("bpAcceptAfterPop", 32'(ack[1]), 32'd1);
        @(posedge clk);
        #1;
        inSend[1] = 1'b0;
        applyStimulus(1, 16'd6, 0);
        applyStimulus(1, 16'd7, 0);
        drain();
        e = '{0, 2, 4, 6};
        compareOuts(1, e, 4, "backPressure");

        // Reset with a stale FIFO entry and a partial group in flight.
        evQ.delete();
        outRdy[2] = 1'b0;
        for (int p = 0; p < 4; p++) applyStimulus(2, 16'd4, 0);
        applyStimulus(2, 16'd100, 0);
        applyStimulus(2, 16'd100, 0);
        outRdy[2] = 1'b1;
        inData[2] = 16'd8;
        inSend[2] = 1'b1;
        rst = 1'b1;
        #1;
        checkOutput("midRstSend", 32'(oSend[2]), 32'd0);
        checkOutput("midRstAck", 32'(ack[2]), 32'd0);
        checkOutput("midRstData", 32'(oData[2]), 32'd0);
        checkOutput("midRstCount", 32'(oCount[2]), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        inSend[2] = 1'b0;
        for (int p = 0; p < 4; p++) applyStimulus(2, 16'd8, 0);
        drain();
        e = '{8, 0, 0, 0};
        compareOuts(2, e, 1, "resetMidGroup");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
